// File: rtl/ms_uart_pkg.sv
// Shared UART definitions: FSM state encoding and line idle level.
// Used by the transmitter now and by the receiver later.
package ms_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_PAR   = 3'd5,
    S_STOP  = 3'd6
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ms_uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and pulses o_bit_end on the last count.
// Synchronous clear holds it at zero; i_div must be >= 1 whenever i_clr is low.
module ms_uart_baud_gen #(
  parameter int DIVW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic [DIVW-1:0] i_div,
  output logic            o_bit_end
);

  logic [DIVW-1:0] r_cnt;
  logic [DIVW-1:0] w_last;

  assign w_last    = i_div - {{(DIVW-1){1'b0}}, 1'b1};
  assign o_bit_end = !i_clr && (r_cnt == w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(DIVW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ms_uart_tx.sv
// UART transmit serializer: pops one byte per frame from the TX FIFO, sends it LSB-first.
// TX and FIFO_RD are registered; frame settings are frozen in LOAD for the whole frame.
module ms_uart_tx
  import ms_uart_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DIVW   = 16
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [DIVW-1:0]   DIVISOR,
  input  logic              PAR_EN,
  input  logic              PAR_ODD,
  input  logic              STOP2,
  input  logic              FIFO_EMPTY,
  input  logic [DWIDTH-1:0] FIFO_DOUT,
  output logic              FIFO_RD,
  output logic              TX,
  output logic              BUSY
);

  localparam int BCW = $clog2(DWIDTH) + 1;

  uart_state_t       r_state;
  uart_state_t       w_state_nxt;
  logic [DWIDTH-1:0] r_shift;
  logic [BCW-1:0]    r_bitcnt;
  logic [DIVW-1:0]   r_div;
  logic              r_par;
  logic              r_par_en;
  logic              r_stop2;
  logic              r_tx;
  logic              r_fifo_rd;
  logic              w_tx_lvl;
  logic              w_bit_end;
  logic              w_baud_clr;

  assign w_baud_clr = (r_state == S_IDLE) || (r_state == S_FETCH) || (r_state == S_LOAD);

  ms_uart_baud_gen #(
    .DIVW (DIVW)
  ) u_baud (
    .i_clk     (CLK),
    .i_rst_n   (RESETN),
    .i_clr     (w_baud_clr),
    .i_div     (r_div),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_lvl    = UART_IDLE_LEVEL;
    case (r_state)
      S_IDLE:  if (!FIFO_EMPTY) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_START;
      S_START: begin
        w_tx_lvl = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx_lvl = r_shift[0];
        if (w_bit_end && (r_bitcnt == BCW'(DWIDTH - 1)))
          w_state_nxt = r_par_en ? S_PAR : S_STOP;
      end
      S_PAR: begin
        w_tx_lvl = r_par;
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        w_tx_lvl = UART_IDLE_LEVEL;
        if (w_bit_end && (!r_stop2 || (r_bitcnt == BCW'(1))))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs lag the state by one clock so TX never sees decode glitches.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_tx      <= UART_IDLE_LEVEL;
      r_fifo_rd <= 1'b0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_div     <= '0;
      r_par     <= 1'b0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
    end else begin
      r_tx      <= w_tx_lvl;
      r_fifo_rd <= (w_state_nxt == S_FETCH);
      case (r_state)
        S_LOAD: begin
          r_shift  <= FIFO_DOUT;
          r_par    <= (^FIFO_DOUT) ^ PAR_ODD;
          r_par_en <= PAR_EN;
          r_stop2  <= STOP2;
          r_div    <= (DIVISOR == '0) ? DIVW'(1) : DIVISOR;
          r_bitcnt <= '0;
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift  <= r_shift >> 1;
            r_bitcnt <= (r_bitcnt == BCW'(DWIDTH - 1)) ? '0 : r_bitcnt + BCW'(1);
          end
        end
        // Bit counter is reused to count the second stop bit.
        S_STOP: begin
          if (w_bit_end) r_bitcnt <= r_bitcnt + BCW'(1);
        end
        default: ;
      endcase
    end
  end

  assign FIFO_RD = r_fifo_rd;
  assign TX      = r_tx;
  assign BUSY    = (r_state != S_IDLE);

endmodule
